// File: rtl/octal_operand_loader.sv
// octal_operand_loader
// Collects two 2-digit octal operands (A then B, most-significant digit first)
// over a valid/ready digit stream, presents them with a borrow-in to an
// external 6-bit borrow subtractor, then registers the returned difference
// until the consumer acknowledges it.
//
// Optional feature: define OCTAL_LOADER_NEG_FLAG_EN to add the result_neg
// output, which flags that the subtraction borrowed out (A < B + cin).
//
// Timing: the edge that accepts the last B digit enters EVAL; during EVAL the
// subtractor sees stable operands, and the following edge captures d_in into
// result and raises result_valid.
module octal_operand_loader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] digit_in,
    input  logic       digit_valid,
    output logic       digit_ready,
    input  logic       borrow_in,
    input  logic       clear,
    output logic [5:0] a_out,
    output logic [5:0] b_out,
    output logic       cin_out,
    input  logic [5:0] d_in,
    output logic [5:0] result,
    output logic       result_valid,
    input  logic       result_ack
`ifdef OCTAL_LOADER_NEG_FLAG_EN
    ,
    output logic       result_neg
`endif
);

    typedef enum logic [2:0] {
        A_HI = 3'd0,
        A_LO = 3'd1,
        B_HI = 3'd2,
        B_LO = 3'd3,
        EVAL = 3'd4,
        HOLD = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] a_q, a_d;
    logic [5:0] b_q, b_d;
    logic       cin_q, cin_d;
    logic [5:0] result_q, result_d;
    logic       result_valid_q, result_valid_d;
    logic       xfer;

    // Handshake: a digit moves only when offered and accepted in the same cycle.
    assign xfer = digit_valid && digit_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= A_HI;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: advance per accepted digit, one pass through EVAL, wait in
    // HOLD for the acknowledge; clear overrides everything.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = A_HI;
        end else begin
            case (state_q)
                A_HI:    if (xfer) state_d = A_LO;
                A_LO:    if (xfer) state_d = B_HI;
                B_HI:    if (xfer) state_d = B_LO;
                B_LO:    if (xfer) state_d = EVAL;
                EVAL:    state_d = HOLD;
                HOLD:    if (result_ack) state_d = A_HI;
                default: state_d = A_HI;
            endcase
        end
    end

    // Outputs decoded from state: digits are accepted only while loading.
    always_comb begin
        digit_ready = (state_q == A_HI) || (state_q == A_LO) ||
                      (state_q == B_HI) || (state_q == B_LO);
    end

    // Operand, borrow and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q            <= 6'd0;
            b_q            <= 6'd0;
            cin_q          <= 1'b0;
            result_q       <= 6'd0;
            result_valid_q <= 1'b0;
        end else begin
            a_q            <= a_d;
            b_q            <= b_d;
            cin_q          <= cin_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Datapath next values: operands are only overwritten by a new load, so
    // they stay stable through EVAL/HOLD and survive a clear.
    always_comb begin
        a_d            = a_q;
        b_d            = b_q;
        cin_d          = cin_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        if (clear) begin
            result_valid_d = 1'b0;
        end else begin
            if (xfer) begin
                case (state_q)
                    A_HI:    a_d[5:3] = digit_in;
                    A_LO:    a_d[2:0] = digit_in;
                    B_HI:    b_d[5:3] = digit_in;
                    B_LO: begin
                        b_d[2:0] = digit_in;
                        cin_d    = borrow_in;
                    end
                    default: ;
                endcase
            end
            if (state_q == EVAL) begin
                result_d       = d_in;
                result_valid_d = 1'b1;
            end
            if ((state_q == HOLD) && result_ack) begin
                result_valid_d = 1'b0;
            end
        end
    end

`ifdef OCTAL_LOADER_NEG_FLAG_EN
    logic       result_neg_q, result_neg_d;
    logic [6:0] sub_rhs;

    // Borrow-out flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_neg_q <= 1'b0;
        end else begin
            result_neg_q <= result_neg_d;
        end
    end

    // Borrow-out flag: 7-bit compare so B + cin cannot wrap; captured with result.
    always_comb begin
        sub_rhs      = {1'b0, b_q} + {6'd0, cin_q};
        result_neg_d = result_neg_q;
        if (clear) begin
            result_neg_d = 1'b0;
        end else if (state_q == EVAL) begin
            result_neg_d = ({1'b0, a_q} < sub_rhs);
        end
    end

    assign result_neg = result_neg_q;
`endif

    assign a_out        = a_q;
    assign b_out        = b_q;
    assign cin_out      = cin_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_octal_operand_loader.sv
// Self-checking bench for octal_operand_loader. A combinational 6-bit borrow
// subtractor is attached to a_out/b_out/cin_out/d_in. Works with or without
// OCTAL_LOADER_NEG_FLAG_EN defined.
module tb_octal_operand_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] digit_in;
    logic       digit_valid;
    logic       digit_ready;
    logic       borrow_in;
    logic       clear;
    logic [5:0] a_out;
    logic [5:0] b_out;
    logic       cin_out;
    logic [5:0] d_in;
    logic [5:0] result;
    logic       result_valid;
    logic       result_ack;
`ifdef OCTAL_LOADER_NEG_FLAG_EN
    logic       result_neg;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Downstream subtractor: 6-bit wrap-around difference.
    assign d_in = a_out - b_out - {5'd0, cin_out};

    octal_operand_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_in     (digit_in),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .borrow_in    (borrow_in),
        .clear        (clear),
        .a_out        (a_out),
        .b_out        (b_out),
        .cin_out      (cin_out),
        .d_in         (d_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack)
`ifdef OCTAL_LOADER_NEG_FLAG_EN
        ,
        .result_neg   (result_neg)
`endif
    );

    typedef struct {
        logic [2:0] d0, d1, d2, d3;
        logic       bin;
        int         exp_a, exp_b, exp_cin, exp_res, exp_neg;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_neg(input string name, input int exp);
`ifdef OCTAL_LOADER_NEG_FLAG_EN
        chk(name, int'(result_neg), exp);
`else
        if (exp < 0) $display("unused %s", name);
`endif
    endtask

    // Offer one digit after 'gap' idle cycles (digit_valid low, junk data);
    // returns at 1ns after the accepting edge.
    task automatic send_digit(input logic [2:0] d, input logic b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            digit_valid = 1'b0;
            digit_in    = 3'($urandom);
            borrow_in   = 1'($urandom);
            @(posedge clk); #1;
        end
        digit_in    = d;
        borrow_in   = b;
        digit_valid = 1'b1;
        n = 0;
        while (!digit_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!digit_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        digit_valid = 1'b0;
        borrow_in   = ~b;
        digit_in    = 3'($urandom);
    endtask

    // Full transaction with wrong borrow_in on the first three digits.
    task automatic run_vec(input vec_t v, input int gap);
        send_digit(v.d0, ~v.bin, gap);
        send_digit(v.d1, ~v.bin, gap);
        send_digit(v.d2, ~v.bin, gap);
        send_digit(v.d3, v.bin, gap);
        // EVAL cycle: junk offered, must not be accepted
        digit_valid = 1'b1;
        digit_in    = 3'($urandom);
        chk("eval_rv", int'(result_valid), 0);
        chk("eval_ready", int'(digit_ready), 0);
        @(posedge clk); #1;
        chk("a_out", int'(a_out), v.exp_a);
        chk("b_out", int'(b_out), v.exp_b);
        chk("cin_out", int'(cin_out), v.exp_cin);
        chk("result", int'(result), v.exp_res);
        chk("result_valid", int'(result_valid), 1);
        chk("hold_ready", int'(digit_ready), 0);
        chk_neg("result_neg", v.exp_neg);
        digit_valid = 1'b0;
        result_ack  = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        chk("ack_rv", int'(result_valid), 0);
        chk("ack_ready", int'(digit_ready), 1);
        chk("ack_result_kept", int'(result), v.exp_res);
    endtask

    function automatic vec_t mk(input int d0, input int d1, input int d2, input int d3, input int bin);
        vec_t v;
        int   a, b;
        a = d0 * 8 + d1;
        b = d2 * 8 + d3;
        v.d0 = 3'(d0); v.d1 = 3'(d1); v.d2 = 3'(d2); v.d3 = 3'(d3);
        v.bin = 1'(bin);
        v.exp_a   = a;
        v.exp_b   = b;
        v.exp_cin = bin;
        v.exp_res = (a - b - bin + 128) % 64;
        v.exp_neg = (a < b + bin) ? 1 : 0;
        return v;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a"}, int'(a_out), 0);
        chk({tag, "_b"}, int'(b_out), 0);
        chk({tag, "_cin"}, int'(cin_out), 0);
        chk({tag, "_res"}, int'(result), 0);
        chk({tag, "_rv"}, int'(result_valid), 0);
        chk({tag, "_ready"}, int'(digit_ready), 1);
        chk_neg({tag, "_neg"}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vectors with hand-derived expectations
        vecs[0] = '{3'd5, 3'd2, 3'd1, 3'd7, 1'b0, 42, 15, 0, 27, 0}; // 0o52-0o17=0o33
        vecs[1] = '{3'd0, 3'd0, 3'd0, 3'd1, 1'b1, 0, 1, 1, 62, 1};   // -> 0o76
        vecs[2] = '{3'd7, 3'd7, 3'd0, 3'd0, 1'b1, 63, 0, 1, 62, 0};
        vecs[3] = '{3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 0, 0, 0, 0, 0};
        vecs[4] = '{3'd0, 3'd0, 3'd7, 3'd7, 1'b1, 0, 63, 1, 0, 1};   // wraps to zero
        vecs[5] = '{3'd3, 3'd4, 3'd3, 3'd4, 1'b1, 28, 28, 1, 63, 1};

        digit_in = 3'd0; digit_valid = 1'b0; borrow_in = 1'b0;
        clear = 1'b0; result_ack = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", int'(digit_ready), 1);

        // Table vectors, back-to-back then with 1,0,0,1 valid toggling
        for (int i = 0; i < 6; i++) run_vec(vecs[i], 0);
        for (int i = 0; i < 6; i++) run_vec(vecs[i], 2);

        // Long HOLD with digit_valid asserted: nothing moves until ack
        send_digit(3'd5, 1'b1, 0);
        send_digit(3'd2, 1'b1, 0);
        send_digit(3'd1, 1'b1, 0);
        send_digit(3'd7, 1'b0, 0);
        @(posedge clk); #1;
        digit_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            digit_in = 3'($urandom);
            @(posedge clk); #1;
            chk("hold_rv", int'(result_valid), 1);
            chk("hold_res", int'(result), 27);
            chk("hold_a", int'(a_out), 42);
        end
        digit_valid = 1'b0;
        result_ack  = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        chk("hold_ack_rv", int'(result_valid), 0);
        chk("hold_ack_ready", int'(digit_ready), 1);

        // Clear together with the B_LO transfer: b_lo and cin not loaded
        send_digit(3'd3, 1'b0, 0);
        send_digit(3'd6, 1'b0, 0);
        send_digit(3'd2, 1'b0, 0);
        digit_in = 3'd5; borrow_in = 1'b1; digit_valid = 1'b1; clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; digit_valid = 1'b0;
        chk("clr_ready", int'(digit_ready), 1);
        chk("clr_a", int'(a_out), 30);      // 0o36
        chk("clr_b", int'(b_out), 23);      // 0o27: old low digit kept
        chk("clr_cin", int'(cin_out), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("clr_no_eval_rv", int'(result_valid), 0);
        end

        // Clear during EVAL suppresses the capture
        send_digit(3'd1, 1'b0, 0);
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd1, 1'b0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_eval_rv", int'(result_valid), 0);
        chk("clr_eval_ready", int'(digit_ready), 1);

        // Clear in HOLD drops result_valid and keeps operands
        run_vec(vecs[1], 0);
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd1, 1'b1, 0);
        @(posedge clk); #1;
        chk("pre_clr_hold_rv", int'(result_valid), 1);
        clear = 1'b1; result_ack = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; result_ack = 1'b0;
        chk("clr_hold_rv", int'(result_valid), 0);
        chk("clr_hold_ready", int'(digit_ready), 1);
        chk("clr_hold_b", int'(b_out), 1);
        chk("clr_hold_cin", int'(cin_out), 1);
        chk_neg("clr_hold_neg", 0);

        // Asynchronous reset in A_LO
        send_digit(3'd7, 1'b0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_alo");
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_alo_ready", int'(digit_ready), 1);

        // Asynchronous reset in HOLD
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd0, 1'b0, 0);
        send_digit(3'd1, 1'b1, 0);
        @(posedge clk); #1;
        chk("pre_rst_hold_rv", int'(result_valid), 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_hold");
        #3 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_ready", int'(digit_ready), 1);
            chk("rst_hold_rv", int'(result_valid), 0);
        end

        // Randomized transactions against the arithmetic reference
        for (int i = 0; i < 30; i++) begin
            vec_t v;
            v = mk(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 1)));
            run_vec(v, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
